// File: rtl/fp_rnd_pipe_if.sv
// Handshake bundle for the rounding/packing pipe: unrounded payload in,
// packed binary32 result plus {NV,DZ,OF,UF,NX} flags out.
interface fp_rnd_pipe_if;

  typedef struct packed {
    logic        sig;
    logic [10:0] expo;
    logic [24:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        diff;
  } fp_rnd_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
  } fp_rnd_out_type;

  logic           in_valid;
  logic           in_ready;
  fp_rnd_in_type  fp_rnd_i;
  logic           out_valid;
  logic           out_ready;
  fp_rnd_out_type fp_rnd_o;

  modport master (
    output in_valid, fp_rnd_i, out_ready,
    input  in_ready, out_valid, fp_rnd_o
  );

  modport slave (
    input  in_valid, fp_rnd_i, out_ready,
    output in_ready, out_valid, fp_rnd_o
  );

endinterface

// File: rtl/fp_rnd_pipe.sv
// Two-stage single-precision rounder/packer.
// S1 decodes specials and decides the round increment; S2 applies the
// increment, renormalises, detects overflow and packs the result.
module fp_rnd_pipe (
  input  logic          clock,
  input  logic          reset,
  fp_rnd_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    KIND_FIN,
    KIND_SNAN,
    KIND_QNAN,
    KIND_DBZ,
    KIND_INF,
    KIND_ZERO
  } kind_t;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // handshake
  logic s1_valid;
  logic out_valid_q;
  logic s1_adv;
  logic s2_adv;

  // stage 1 decode (combinational from the input payload)
  kind_t d_kind;
  logic  d_inc;
  logic  d_nx;
  logic  d_to_max;
  logic  d_zero_sign;

  // stage 1 payload registers (not reset)
  kind_t       s1_kind;
  logic        s1_sig;
  logic [10:0] s1_expo;
  logic [23:0] s1_mant;
  logic        s1_inc;
  logic        s1_nx;
  logic        s1_to_max;
  logic        s1_zero_sign;

  // stage 2 datapath
  logic [24:0] m_sum;
  logic [23:0] m_norm;
  logic [11:0] e_rnd;
  logic        ovf;
  logic        nx_fin;
  logic        uf_fin;
  logic [31:0] s2_result;
  logic [4:0]  s2_flags;

  // output registers
  logic [31:0] result_q;
  logic [4:0]  flags_q;

  // rema, fmt and the guard-carry bit mant[24] carry no information here
  logic unused_fields;
  assign unused_fields = ^{bus.fp_rnd_i.rema, bus.fp_rnd_i.fmt, bus.fp_rnd_i.mant[24]};

  assign s2_adv       = ~out_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.fp_rnd_o  = {result_q, flags_q};

  // S1 decode: special-case priority, round increment and sticky inexact
  always_comb begin
    logic g_bit, r_bit, s_bit, l_bit, sig;
    logic [2:0] rm;
    g_bit = bus.fp_rnd_i.grs[2];
    r_bit = bus.fp_rnd_i.grs[1];
    s_bit = bus.fp_rnd_i.grs[0];
    l_bit = bus.fp_rnd_i.mant[0];
    sig   = bus.fp_rnd_i.sig;
    rm    = bus.fp_rnd_i.rm;

    d_kind = KIND_FIN;
    if (bus.fp_rnd_i.snan)      d_kind = KIND_SNAN;
    else if (bus.fp_rnd_i.qnan) d_kind = KIND_QNAN;
    else if (bus.fp_rnd_i.dbz)  d_kind = KIND_DBZ;
    else if (bus.fp_rnd_i.inf)  d_kind = KIND_INF;
    else if (bus.fp_rnd_i.zero) d_kind = KIND_ZERO;

    // unsupported encodings 5-7 fall back to round-to-nearest-even
    case (rm)
      RM_RTZ:  d_inc = 1'b0;
      RM_RDN:  d_inc = sig & (g_bit | r_bit | s_bit);
      RM_RUP:  d_inc = ~sig & (g_bit | r_bit | s_bit);
      RM_RMM:  d_inc = g_bit;
      default: d_inc = g_bit & (r_bit | s_bit | l_bit);
    endcase

    d_nx = g_bit | r_bit | s_bit;

    // modes that round toward zero for this sign saturate at max finite
    d_to_max = (rm == RM_RTZ) | ((rm == RM_RDN) & ~sig) | ((rm == RM_RUP) & sig);

    // exact-zero difference takes -0 only when rounding down
    d_zero_sign = bus.fp_rnd_i.diff ? (rm == RM_RDN) : sig;
  end

  // S1 payload capture on input transfer; data path carries no reset
  always_ff @(posedge clock) begin
    if (s1_adv && bus.in_valid) begin
      s1_kind      <= d_kind;
      s1_sig       <= bus.fp_rnd_i.sig;
      s1_expo      <= bus.fp_rnd_i.expo;
      s1_mant      <= bus.fp_rnd_i.mant[23:0];
      s1_inc       <= d_inc;
      s1_nx        <= d_nx;
      s1_to_max    <= d_to_max;
      s1_zero_sign <= d_zero_sign;
    end
  end

  // S2 datapath: increment, renormalise, overflow/underflow and pack
  always_comb begin
    m_sum  = {1'b0, s1_mant} + {24'd0, s1_inc};
    m_norm = m_sum[23:0];
    e_rnd  = {1'b0, s1_expo};
    if (m_sum[24]) begin
      m_norm = m_sum[24:1];
      e_rnd  = {1'b0, s1_expo} + 12'd1;
    end else if ((s1_expo == 11'd0) && m_sum[23]) begin
      e_rnd = 12'd1;
    end

    ovf    = (e_rnd >= 12'd255);
    nx_fin = s1_nx | ovf;
    uf_fin = nx_fin & (e_rnd == 12'd0);

    s2_result = {s1_sig, e_rnd[7:0], m_norm[22:0]};
    s2_flags  = {3'b000, uf_fin, nx_fin};
    case (s1_kind)
      KIND_SNAN: begin
        s2_result = 32'h7FC0_0000;
        s2_flags  = 5'b10000;
      end
      KIND_QNAN: begin
        s2_result = 32'h7FC0_0000;
        s2_flags  = 5'b00000;
      end
      KIND_DBZ: begin
        s2_result = {s1_sig, 8'hFF, 23'd0};
        s2_flags  = 5'b01000;
      end
      KIND_INF: begin
        s2_result = {s1_sig, 8'hFF, 23'd0};
        s2_flags  = 5'b00000;
      end
      KIND_ZERO: begin
        s2_result = {s1_zero_sign, 31'd0};
        s2_flags  = 5'b00000;
      end
      default: begin
        if (ovf) begin
          s2_result = s1_to_max ? {s1_sig, 31'h7F7F_FFFF} : {s1_sig, 31'h7F80_0000};
          s2_flags  = 5'b00101;
        end
      end
    endcase
  end

  // valid bits and output registers; reset discards everything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      flags_q     <= 5'd0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          result_q <= s2_result;
          flags_q  <= s2_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe: hand-computed rounding vectors,
// backpressure ordering and mid-flight reset.
module tb_fp_rnd_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fp_rnd_pipe_if bus ();

  fp_rnd_pipe dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison: count it, report it when it differs
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // spec bits: {snan,qnan,dbz,inf,zero,diff}
  task automatic drive(input logic sig, input logic [10:0] expo, input logic [24:0] mant,
                       input logic [2:0] grs, input logic [2:0] rm, input logic [5:0] spec);
    bus.fp_rnd_i.sig  = sig;
    bus.fp_rnd_i.expo = expo;
    bus.fp_rnd_i.mant = mant;
    bus.fp_rnd_i.grs  = grs;
    bus.fp_rnd_i.rm   = rm;
    bus.fp_rnd_i.rema = 2'b00;
    bus.fp_rnd_i.fmt  = 2'b00;
    {bus.fp_rnd_i.snan, bus.fp_rnd_i.qnan, bus.fp_rnd_i.dbz,
     bus.fp_rnd_i.inf, bus.fp_rnd_i.zero, bus.fp_rnd_i.diff} = spec;
  endtask

  // single transfer with the consumer always ready; checks latency too
  task automatic send(input string tag, input logic sig, input logic [10:0] expo,
                      input logic [24:0] mant, input logic [2:0] grs, input logic [2:0] rm,
                      input logic [5:0] spec, input logic [31:0] exp_res, input logic [4:0] exp_fl);
    drive(sig, expo, mant, grs, rm, spec);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"}, bus.fp_rnd_o.result, exp_res);
    check({tag, "_flags"}, 32'(bus.fp_rnd_o.flags), 32'(exp_fl));
  endtask

  logic [31:0] bp_exp [4];
  int          idx;
  int          nout;
  int          stale;
  logic        acc;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 11'd0, 25'd0, 3'd0, 3'd0, 6'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.fp_rnd_o.result, 32'd0);
    check("rst_flags", 32'(bus.fp_rnd_o.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    //   tag        sig expo     mant         grs     rm    spec       result        flags
    send("one",     0, 11'd127, 25'h0800000, 3'b000, 3'd0, 6'b000000, 32'h3F800000, 5'h00);
    send("tie_odd", 0, 11'd127, 25'h0800001, 3'b100, 3'd0, 6'b000000, 32'h3F800002, 5'h01);
    send("tie_even",0, 11'd127, 25'h0800000, 3'b100, 3'd0, 6'b000000, 32'h3F800000, 5'h01);
    send("tie_rmm", 0, 11'd127, 25'h0800000, 3'b100, 3'd4, 6'b000000, 32'h3F800001, 5'h01);
    send("rm5_rne", 0, 11'd127, 25'h0800001, 3'b100, 3'd5, 6'b000000, 32'h3F800002, 5'h01);
    send("rdn_neg", 1, 11'd127, 25'h0800000, 3'b010, 3'd2, 6'b000000, 32'hBF800001, 5'h01);
    send("carry",   0, 11'd127, 25'h0FFFFFF, 3'b100, 3'd0, 6'b000000, 32'h40000000, 5'h01);
    send("ovf_rne", 0, 11'd254, 25'h0FFFFFF, 3'b110, 3'd0, 6'b000000, 32'h7F800000, 5'h05);
    // truncation keeps e=254, so this one is inexact but not an overflow
    send("max_rtz", 0, 11'd254, 25'h0FFFFFF, 3'b110, 3'd1, 6'b000000, 32'h7F7FFFFF, 5'h01);
    send("ovf_rtz", 0, 11'd255, 25'h0800000, 3'b000, 3'd1, 6'b000000, 32'h7F7FFFFF, 5'h05);
    send("ovf_rupn",1, 11'd255, 25'h0800000, 3'b000, 3'd3, 6'b000000, 32'hFF7FFFFF, 5'h05);
    send("ovf_rdnn",1, 11'd255, 25'h0800000, 3'b000, 3'd2, 6'b000000, 32'hFF800000, 5'h05);
    send("sub_prom",0, 11'd0,   25'h07FFFFF, 3'b100, 3'd0, 6'b000000, 32'h00800000, 5'h01);
    send("sub_uf",  0, 11'd0,   25'h0000001, 3'b001, 3'd3, 6'b000000, 32'h00000002, 5'h03);
    send("snan",    0, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b100000, 32'h7FC00000, 5'h10);
    send("qnan",    1, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b010000, 32'h7FC00000, 5'h00);
    send("dbz_neg", 1, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b001000, 32'hFF800000, 5'h08);
    send("inf_pos", 0, 11'd0,   25'h0000000, 3'b111, 3'd0, 6'b000100, 32'h7F800000, 5'h00);
    send("zero_rdn",0, 11'd0,   25'h0000000, 3'b000, 3'd2, 6'b000011, 32'h80000000, 5'h00);
    send("zero_rne",1, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b000011, 32'h00000000, 5'h00);
    send("zero_sig",1, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b000010, 32'h80000000, 5'h00);
    send("prio",    0, 11'd0,   25'h0000000, 3'b000, 3'd0, 6'b110110, 32'h7FC00000, 5'h10);
    tick();

    // backpressure: four back-to-back inputs, consumer stalled for 3 cycles
    bp_exp[0] = 32'h3F800000;
    bp_exp[1] = 32'h40000000;
    bp_exp[2] = 32'h40800000;
    bp_exp[3] = 32'h41000000;
    idx  = 0;
    nout = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.out_ready = (cyc >= 3);
      bus.in_valid  = (idx < 4);
      drive(1'b0, 11'(127 + idx), 25'h0800000, 3'b000, 3'd0, 6'd0);
      #1;
      if (cyc == 2) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_accepts", 32'(idx), 32'd2);
      end
      if (bus.out_valid && nout < 4) begin
        check("bp_res", bus.fp_rnd_o.result, bp_exp[nout]);
      end
      if (bus.out_valid && bus.out_ready) nout++;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    check("bp_delivered", 32'(nout), 32'd4);
    check("bp_sent", 32'(idx), 32'd4);

    // reset with two payloads in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(1'b0, 11'd127, 25'h0800000, 3'b000, 3'd0, 6'd0);
    tick();
    drive(1'b0, 11'd128, 25'h0800000, 3'b000, 3'd0, 6'd0);
    tick();
    check("mid_full_valid", 32'(bus.out_valid), 32'd1);
    check("mid_full_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) stale++;
      tick();
    end
    check("mid_no_stale", 32'(stale), 32'd0);

    send("post_rst", 0, 11'd128, 25'h0C00000, 3'b000, 3'd0, 6'b000000, 32'h40400000, 5'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
